// File: rtl/dpsk_demod.sv
// Differential DPSK demodulator: multiplies each sample by the one a symbol earlier,
// integrates the products over a symbol and decides the bit from the sign of the sum.
module dpsk_demod #(
  parameter int SPS   = 50,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_en,
  input  logic [7:0]              sample_in,
  input  logic                    sym_sync,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic signed [ACC_W-1:0] acc_out
);

  localparam int            CW   = $clog2(SPS);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  logic signed [7:0]       s_conv;
  logic signed [7:0]       d_ref;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] sum;

  logic signed [7:0]       dly_q [SPS];
  logic signed [7:0]       dly_d [SPS];
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [15:0]      p_q, p_d;
  logic                    p_vld_q, p_vld_d;
  logic                    p_last_q, p_last_d;
  logic                    p_sync_q, p_sync_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    bit_out_q, bit_out_d;
  logic                    bit_valid_q, bit_valid_d;
  logic                    primed_q, primed_d;

  // Offset binary to two's complement: flip the MSB.
  assign s_conv = {~sample_in[7], sample_in[6:0]};
  assign d_ref  = dly_q[SPS-1];
  assign prod   = s_conv * d_ref;
  assign p_ext  = {{(ACC_W-16){p_q[15]}}, p_q};

  always_comb begin
    dly_d = dly_q;
    cnt_d = cnt_q;
    if (sample_en) begin
      dly_d[0] = s_conv;
      for (int i = 1; i < SPS; i++) begin
        dly_d[i] = dly_q[i-1];
      end
      if (sym_sync) begin
        cnt_d = CW'(1);
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    p_d      = p_q;
    p_vld_d  = 1'b0;
    p_last_d = p_last_q;
    p_sync_d = p_sync_q;
    if (sample_en) begin
      p_d      = prod;
      p_vld_d  = 1'b1;
      p_last_d = (cnt_q == LAST);
      p_sync_d = sym_sync;
    end
  end

  // A sync sample restarts integration and discards the partial symbol; it beats a dump.
  always_comb begin
    sum         = acc_q + p_ext;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    primed_d    = primed_q;
    if (p_vld_q) begin
      if (p_sync_q) begin
        acc_d = p_ext;
      end else if (p_last_q) begin
        acc_out_d   = sum;
        bit_out_d   = sum[ACC_W-1];
        acc_d       = '0;
        bit_valid_d = primed_q;
        primed_d    = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SPS; i++) begin
        dly_q[i] <= '0;
      end
      cnt_q       <= '0;
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      p_last_q    <= 1'b0;
      p_sync_q    <= 1'b0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      p_vld_q     <= p_vld_d;
      p_last_q    <= p_last_d;
      p_sync_q    <= p_sync_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      primed_q    <= primed_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign acc_out   = acc_out_q;

endmodule

// File: tb/tb_dpsk_demod.sv
// Scoreboard bench for dpsk_demod: directed symbol patterns push expected decisions,
// a monitor pops and checks bit, sum and arrival cycle on every bit_valid.
module tb_dpsk_demod;

  localparam int SPS   = 50;
  localparam int ACC_W = 24;
  localparam logic signed [ACC_W-1:0] SUM_POS = 24'sd806450;
  localparam logic signed [ACC_W-1:0] SUM_NEG = -24'sd812800;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    sample_en = 1'b0;
  logic [7:0]              sample_in = 8'd128;
  logic                    sym_sync = 1'b0;
  logic                    bit_out;
  logic                    bit_valid;
  logic signed [ACC_W-1:0] acc_out;

  typedef struct {
    logic                    b;
    logic signed [ACC_W-1:0] a;
    int                      c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc  = 0;
  int   vecs = 0;
  int   errs = 0;

  dpsk_demod #(.SPS(SPS), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .sample_in (sample_in),
    .sym_sync  (sym_sync),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bit_valid) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_valid cyc=%0d bit=%0b acc=%0d", cyc, bit_out, acc_out);
      end else begin
        e = exp_q.pop_front();
        vecs++;
        if (bit_out !== e.b) begin
          errs++;
          $display("FAIL bit cyc=%0d got=%0b exp=%0b", cyc, bit_out, e.b);
        end
        vecs++;
        if (acc_out !== e.a) begin
          errs++;
          $display("FAIL acc cyc=%0d got=%0d exp=%0d", cyc, acc_out, e.a);
        end
        vecs++;
        if (cyc != e.c) begin
          errs++;
          $display("FAIL valid_cycle got=%0d exp=%0d", cyc, e.c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", name, $signed(got), $signed(exp));
    end
  endtask

  task automatic smp(input logic [7:0] x, input logic sy);
    @(negedge clk);
    sample_en = 1'b1;
    sample_in = x;
    sym_sync  = sy;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      sample_en = 1'b0;
      sym_sync  = 1'b0;
    end
  endtask

  // Called in the same slot as the sample that closes the symbol.
  task automatic expect_dec(input logic b, input logic signed [ACC_W-1:0] a);
    exp_t e;
    e.b = b;
    e.a = a;
    e.c = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    idle(4);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, {31'd0, bit_valid}, 32'd0);
    check({tag, "_rst_bit"}, {31'd0, bit_out}, 32'd0);
    check({tag, "_rst_acc"}, 32'(acc_out), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  initial begin
    #1;
    check("por_valid", {31'd0, bit_valid}, 32'd0);
    check("por_bit", {31'd0, bit_out}, 32'd0);
    check("por_acc", 32'(acc_out), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Constant in-phase: warm-up symbol silent, then four zero bits.
    for (int n = 1; n <= 250; n++) begin
      smp(8'd255, 1'b0);
      if (n >= 100 && n % SPS == 0) expect_dec(1'b0, SUM_POS);
    end
    do_reset("const");

    // Alternating phase: every reported bit is 1.
    for (int n = 1; n <= 250; n++) begin
      smp(((n - 1) / SPS) % 2 == 0 ? 8'd255 : 8'd0, 1'b0);
      if (n >= 100 && n % SPS == 0) expect_dec(1'b1, SUM_NEG);
    end
    do_reset("alt");

    // Stalled input at 50% duty: decisions 100 clk apart, outputs hold in gaps.
    for (int n = 1; n <= 250; n++) begin
      smp(8'd255, 1'b0);
      if (n >= 100 && n % SPS == 0) expect_dec(1'b0, SUM_POS);
      idle(1);
    end
    idle(30);
    check("stall_hold_bit", {31'd0, bit_out}, 32'd0);
    check("stall_hold_acc", 32'(acc_out), 32'(SUM_POS));
    do_reset("stall");

    // Realign at sample 20 of symbol 3: truncated symbol unreported.
    for (int n = 1; n <= 220; n++) begin
      smp(8'd255, n == 120);
      if (n == 100 || n == 169 || n == 219) expect_dec(1'b0, SUM_POS);
    end
    do_reset("sync");

    // Sync on the last sample of a symbol: sync wins, no dump there.
    for (int n = 1; n <= 150; n++) begin
      smp(8'd255, n == 100);
      if (n == 149) expect_dec(1'b0, SUM_POS);
    end
    do_reset("wrapsync");

    // Zero-product symbol decodes as 0 with a zero sum.
    for (int n = 1; n <= 150; n++) begin
      smp(n <= 100 ? 8'd255 : 8'd128, 1'b0);
      if (n == 100) expect_dec(1'b0, SUM_POS);
      if (n == 150) expect_dec(1'b0, '0);
    end
    do_reset("zero");

    // Mid-symbol reset at sample 30 of symbol 2; primed must clear.
    for (int n = 1; n <= 79; n++) smp(8'd255, 1'b0);
    @(negedge clk);
    sample_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bit_valid}, 32'd0);
    check("mid_rst_bit", {31'd0, bit_out}, 32'd0);
    check("mid_rst_acc", 32'(acc_out), 32'd0);
    idle(3);
    reset_n = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      smp(8'd255, 1'b0);
      if (n == 100 || n == 150) expect_dec(1'b0, SUM_POS);
    end
    idle(6);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/dpsk_demod.md
# dpsk_demod

Differential-coherent DPSK demodulator. It consumes the 8-bit offset-binary modulated carrier produced by the `dpsk_code` stage and recovers the original serial bit stream. Each sample is multiplied by the sample exactly one symbol earlier, and the products are integrated over each symbol. The sign of the sum gives the bit: negative means a phase inversion, decoded as 1; positive means no inversion, decoded as 0. The block sits directly downstream of the modulator in the loopback chain and feeds the bit checker.

## Interface
Parameters:
- `SPS`, default 50: samples per symbol. Range 2..255.
- `ACC_W`, default 24: signed accumulator width. Must be ≥ 16 + ceil(log2(SPS)) + 1.

Ports:
- `clk`  in  1: system clock. Same clock that drives the Sin/Cos DDS.
- `reset_n`  in  1: asynchronous, active-low reset.
- `sample_en`  in  1: qualifies `sample_in`. One sample is accepted per clk while this is high.
- `sample_in`  in  8: modulated carrier in offset binary (8'd128 = zero).
- `sym_sync`  in  1: symbol-boundary realign. Only effective together with `sample_en`.
- `bit_out`  out  1: recovered bit. Held until the next decision.
- `bit_valid`  out  1: one-clk pulse when `bit_out` is updated.
- `acc_out`  out  ACC_W: signed integrate-and-dump sum of the last decided symbol. Used for debug and margin checks.

## Operation
- **Sample conversion:** s = {~sample_in[7], sample_in[6:0]}, interpreted as signed 8-bit (-128..127).
- **Delay line:**
  - SPS × 8-bit shift register. It advances only on `sample_en`.
  - d = the converted sample accepted exactly SPS accepted samples earlier.
  - Reset clears it to 0.
- **Multiply stage (pipeline register P1):**
  - On `sample_en`: p <= s*d (signed 16-bit; range -16256..16384, no overflow).
  - `p_vld` <= 1; `p_last` <= (cnt == SPS-1); `p_sync` <= `sym_sync`.
  - Otherwise `p_vld` <= 0.
- **Symbol counter `cnt`:**
  - Range 0..SPS-1. Increments on `sample_en` and wraps SPS-1 → 0.
  - `sym_sync`&`sample_en` forces `cnt` <= 1, meaning the current sample becomes index 0.
- **Accumulate stage (acts on `p_vld`):**
  - `p_sync` = 1: acc <= sext(p). The partial symbol is discarded and no decision is made.
  - `p_last` = 1 and `p_sync` = 0 (dump):
    - Let sum = acc + sext(p). Then `acc_out` <= sum, `bit_out` <= sum[ACC_W-1], acc <= 0.
    - `bit_valid` <= `primed`; `primed` <= 1.
  - Otherwise: acc <= acc + sext(p).
  - A sum of exactly 0 decodes as 0.
- **Warm-up:**
  - The first complete symbol after reset has no valid reference, because the delay line holds zeros.
  - Its dump updates `acc_out`/`bit_out` but keeps `bit_valid` = 0, and sets `primed`.
  - `sym_sync` does not clear `primed`.
- **Precedence:** `sym_sync` overrides `p_last` when both are set on the same sample.
- **Counter wrap and sync:** when `cnt` = SPS-1 and `sym_sync` arrive together, the sync value (1) wins.

## Timing
- **Reset values:** `bit_out` = 0, `bit_valid` = 0, `acc_out` = 0. Internal state also clears: acc = 0, `cnt` = 0, `primed` = 0, P1 = 0, delay line = 0.
- **Latency:** `bit_valid` rises 2 clk after the `sample_en` cycle that carries the last sample of a symbol.
  - Edge 1 registers P1.
  - Edge 2 registers the decision.
- **`bit_valid`:** exactly 1 clk wide, at most once per SPS accepted samples.
- **Stalls:** `sample_en` low stalls everything. `cnt`, acc and the delay line hold. A P1 entry already captured still completes on the next clk.
- **Reset mid-symbol:** all state clears asynchronously, including `primed`. After release, the next SPS samples form a non-reported warm-up symbol.
- **Throughput:** continuous `sample_en` = 1 is supported with no bubbles.

## Test plan
- **Constant in-phase:** reset, then `sample_en` = 1 and `sample_in` = 8'd255 for 5 symbols (SPS = 50).
  - No `bit_valid` in the first 50 samples.
  - Then 4 pulses with `bit_out` = 0 and `acc_out` = 50 × 16129 = 806450.
  - The first pulse is 2 clk after sample 100.
- **Alternating phase:** symbols alternate between 8'd255 and 8'd0 (s = -128).
  - Every reported bit is 1.
  - `acc_out` = 50 × (-16256) = -812800.
- **Loopback with `dpsk_code`:** drive the modulator with m_ser toggling every 50 clk and connect its 8-bit output here.
  - Recovered bits equal the source bits from symbol 2 on.
  - Recovered bits lag the source by 1 symbol + 2 clk.
- **Stalled input:** the constant pattern with `sample_en` at a 50% duty.
  - Same bits and `acc_out` as the constant in-phase case.
  - `bit_valid` spacing = 100 clk; outputs hold during gaps.
- **Realign:** pulse `sym_sync` at sample 20 of symbol 3.
  - No `bit_valid` for the truncated symbol.
  - The next decision comes SPS samples after the sync sample.
- **Mid-symbol reset:** assert `reset_n` = 0 at sample 30 of symbol 2.
  - All outputs read 0 immediately.
  - After release, the first `bit_valid` occurs 2 clk after the 100th accepted sample.
